// File: rtl/activation_lut_sequencer.sv
// activation_lut_sequencer
// One shared 16-entry activation LUT serves every neuron of a layer.
// Each pre-activation is split into a LUT address (upper bits) and a
// fraction (lower bits). The sequencer then interpolates linearly between
// the addressed entry and its partner entry, and streams out saturated
// results framed per layer. Each item takes four cycles: IDLE, LOOK, CALC, EMIT.
module activation_lut_sequencer #(
  parameter int NEURONS = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] lut_address,
  input  logic [DATA_W-1:0] lut_base,
  input  logic [DATA_W-1:0] lut_next,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [7:0]        neuron_idx,
  output logic              layer_done
);

  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int DIFF_W = DATA_W + 1;
  localparam int PROD_W = DIFF_W + FRAC_W + 1;
  localparam logic [7:0] LAST_IDX = 8'(NEURONS - 1);
  localparam logic signed [PROD_W-1:0] RES_MAX = PROD_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] RES_MIN = PROD_W'(-(2 ** (DATA_W - 1)));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOOK = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  // Clamp a wide signed interpolation result to the DATA_W signed range.
  function automatic logic [DATA_W-1:0] saturate(input logic signed [PROD_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v > RES_MAX) begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < RES_MIN) begin
      r = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] next_q, next_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [7:0]        idx_q, idx_d;
  logic              done_q, done_d;

  logic signed [DIFF_W-1:0] diff_s;
  logic signed [PROD_W-1:0] diff_ext_s;
  logic signed [PROD_W-1:0] frac_ext_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] shift_s;
  logic signed [PROD_W-1:0] base_ext_s;
  logic signed [PROD_W-1:0] res_s;

  assign in_ready    = (state_q == S_IDLE);
  assign lut_address = addr_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_last    = last_q;
  assign neuron_idx  = idx_q;
  assign layer_done  = done_q;

  // Interpolation datapath: base + floor((next - base) * frac / 2^FRAC_W).
  always_comb begin
    diff_s     = $signed({next_q[DATA_W-1], next_q}) - $signed({base_q[DATA_W-1], base_q});
    diff_ext_s = {{(PROD_W-DIFF_W){diff_s[DIFF_W-1]}}, diff_s};
    frac_ext_s = {{(PROD_W-FRAC_W){1'b0}}, frac_q};
    prod_s     = diff_ext_s * frac_ext_s;
    shift_s    = prod_s >>> FRAC_W;
    base_ext_s = {{(PROD_W-DATA_W){base_q[DATA_W-1]}}, base_q};
    res_s      = base_ext_s + shift_s;
  end

  // Sequencer next-state logic: accept, look up, compute, then hold until taken.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    frac_d  = frac_q;
    base_d  = base_q;
    next_d  = next_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d  = in_data[DATA_W-1 -: ADDR_W];
          frac_d  = in_data[FRAC_W-1:0];
          state_d = S_LOOK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOK: begin
        base_d  = lut_base;
        next_d  = lut_next;
        state_d = S_CALC;
      end
      S_CALC: begin
        data_d  = saturate(res_s);
        valid_d = 1'b1;
        last_d  = (idx_q == LAST_IDX);
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
          if (idx_q == LAST_IDX) begin
            idx_d  = 8'd0;
            done_d = 1'b1;
          end else begin
            idx_d  = idx_q + 8'd1;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset that abandons any item in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      frac_q  <= {FRAC_W{1'b0}};
      base_q  <= {DATA_W{1'b0}};
      next_q  <= {DATA_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      frac_q  <= frac_d;
      base_q  <= base_d;
      next_q  <= next_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_activation_lut_sequencer.sv
// Self-checking bench for activation_lut_sequencer with a behavioural LUT
// and an arithmetic reference model of the interpolation.
module tb_activation_lut_sequencer;

  localparam int NEURONS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] lut_address;
  logic [7:0] lut_base;
  logic [7:0] lut_next;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [7:0] neuron_idx;
  logic       layer_done;

  int errors   = 0;
  int checks   = 0;
  int exp_idx  = 0;
  int done_cnt = 0;

  // LUT model: entry 7 is the top positive entry (partner = itself), 15 wraps to 0.
  logic signed [7:0] lut [16];
  logic [3:0] next_a;
  assign next_a   = lut_address + 4'd1;
  assign lut_base = lut[lut_address];
  assign lut_next = (lut_address == 4'd7) ? lut[4'd7] : lut[next_a];

  activation_lut_sequencer #(.NEURONS(NEURONS), .DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lut_address(lut_address), .lut_base(lut_base), .lut_next(lut_next),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .neuron_idx(neuron_idx), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  // Count layer_done cycles as seen at each rising edge.
  always @(posedge clk) begin
    if (layer_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Reference: base + floor(diff * frac / 16), clamped to [-128, 127].
  function automatic logic [7:0] ref_act(input logic [7:0] d);
    int a, f, b, n, p, q, r;
    a = d >> 4;
    f = d & 8'h0F;
    b = lut[a];
    n = (a == 7) ? lut[7] : lut[(a + 1) % 16];
    p = (n - b) * f;
    q = p / 16;
    if ((p % 16) != 0 && p < 0) q = q - 1;
    r = b + q;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return 8'(r);
  endfunction

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) lut[i] = (i < 8) ? 8'(i * 16) : 8'sd0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) lut[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_idx = 0;
  endtask

  // Drive one item through a full handshake and report what was observed.
  task automatic run_item(input logic [7:0] d, input int stall,
                          output logic [7:0] o_data, output logic o_last,
                          output logic [7:0] o_idx, output logic [3:0] o_addr,
                          output int o_lat, output logic o_stable, output logic o_done);
    int k;
    @(negedge clk); in_valid = 1'b1; in_data = d;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom); o_addr = lut_address;
    k = 1;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    o_lat = out_valid ? (k - 1) : -1;
    o_data = out_data; o_last = out_last; o_idx = neuron_idx; o_stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== o_data || out_last !== o_last) o_stable = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0; o_done = layer_done;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (layer_done !== 1'b0) begin errors++; $display("FAIL reset_layer_done: got %b expected 0", layer_done); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    checks++; if (lut_address !== 4'd0) begin errors++; $display("FAIL reset_lut_address: got %0d expected 0", lut_address); end
    checks++; if (neuron_idx !== 8'd0) begin errors++; $display("FAIL reset_neuron_idx: got %0d expected 0", neuron_idx); end
    rst = 1'b0; in_valid = 1'b0;
    exp_idx = 0;
  endtask

  task automatic test_ramp();
    logic [7:0] ds [4] = '{8'h25, 8'h7F, 8'hF8, 8'h85};
    logic [7:0] ed [4] = '{8'd37, 8'd112, 8'd0, 8'd0};
    logic [3:0] ea [4] = '{4'd2, 4'd7, 4'd15, 4'd8};
    logic [7:0] od, oi; logic ol, os, odn; logic [3:0] oa; int lat;
    load_ramp();
    for (int i = 0; i < 4; i++) begin
      run_item(ds[i], 3, od, ol, oi, oa, lat, os, odn);
      checks++; if (od !== ed[i]) begin errors++; $display("FAIL ramp_data[%0d]: got %0d expected %0d", i, $signed(od), $signed(ed[i])); end
      checks++; if (oa !== ea[i]) begin errors++; $display("FAIL ramp_addr[%0d]: got %0d expected %0d", i, oa, ea[i]); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL ramp_latency[%0d]: got %0d expected 2", i, lat); end
      checks++; if (os !== 1'b1) begin errors++; $display("FAIL ramp_hold[%0d]: output changed while stalled", i); end
      checks++; if (oi !== 8'(exp_idx)) begin errors++; $display("FAIL ramp_idx[%0d]: got %0d expected %0d", i, oi, exp_idx); end
      exp_idx = (exp_idx + 1) % NEURONS;
    end
    // lut_address keeps the last accepted address while idle.
    checks++; if (lut_address !== 4'd8) begin errors++; $display("FAIL ramp_addr_hold: got %0d expected 8", lut_address); end
  endtask

  task automatic test_downward();
    logic [7:0] ds [3] = '{8'h3F, 8'h5F, 8'h0F};
    logic [7:0] ed [3] = '{8'hA8, 8'h80, 8'h8F};  // -88, -128, -113
    logic [7:0] od, oi; logic ol, os, odn; logic [3:0] oa; int lat;
    load_ramp();
    lut[3] = 8'sd100;  lut[4] = -8'sd100;
    // Floor toward minus infinity lands exactly on the negative limit here.
    lut[5] = -8'sd127; lut[6] = -8'sd128;
    lut[0] = 8'sd127;  lut[1] = -8'sd128;
    for (int i = 0; i < 3; i++) begin
      run_item(ds[i], 1, od, ol, oi, oa, lat, os, odn);
      checks++; if (od !== ed[i]) begin errors++; $display("FAIL down_data[%0d]: got %0d expected %0d", i, $signed(od), $signed(ed[i])); end
      exp_idx = (exp_idx + 1) % NEURONS;
    end
  endtask

  task automatic test_frame();
    logic [7:0] od, oi; logic ol, os, odn; logic [3:0] oa; int lat, d0;
    load_ramp();
    do_reset();
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      run_item(8'((i + 1) * 16), 3, od, ol, oi, oa, lat, os, odn);
      checks++; if (od !== 8'((i + 1) * 16)) begin errors++; $display("FAIL frame_data[%0d]: got %0d expected %0d", i, od, (i + 1) * 16); end
      checks++; if (ol !== (i == 3)) begin errors++; $display("FAIL frame_last[%0d]: got %b expected %b", i, ol, (i == 3)); end
      checks++; if (oi !== 8'(i)) begin errors++; $display("FAIL frame_idx[%0d]: got %0d expected %0d", i, oi, i); end
      checks++; if (odn !== (i == 3)) begin errors++; $display("FAIL frame_done[%0d]: got %b expected %b", i, odn, (i == 3)); end
      checks++; if (os !== 1'b1) begin errors++; $display("FAIL frame_hold[%0d]: output changed while stalled", i); end
      exp_idx = (exp_idx + 1) % NEURONS;
    end
    @(negedge clk);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (neuron_idx !== 8'd0) begin errors++; $display("FAIL frame_idx_wrap: got %0d expected 0", neuron_idx); end
  endtask

  task automatic test_reset_emit();
    logic [7:0] od, oi; logic ol, os, odn; logic [3:0] oa; int lat, k, d0;
    load_ramp();
    run_item(8'h10, 0, od, ol, oi, oa, lat, os, odn);
    exp_idx = (exp_idx + 1) % NEURONS;
    d0 = done_cnt;
    @(negedge clk); in_valid = 1'b1; in_data = 8'h20;
    @(negedge clk); in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin @(negedge clk); k++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstemit_reach: got out_valid %b expected 1", out_valid); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstemit_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstemit_ready: got %b expected 1", in_ready); end
    checks++; if (neuron_idx !== 8'd0) begin errors++; $display("FAIL rstemit_idx: got %0d expected 0", neuron_idx); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL rstemit_data: got %0d expected 0", out_data); end
    exp_idx = 0;
    run_item(8'h30, 2, od, ol, oi, oa, lat, os, odn);
    checks++; if (od !== 8'd48) begin errors++; $display("FAIL rstemit_next_data: got %0d expected 48", od); end
    checks++; if (oi !== 8'd0) begin errors++; $display("FAIL rstemit_next_idx: got %0d expected 0", oi); end
    checks++; if (ol !== 1'b0) begin errors++; $display("FAIL rstemit_next_last: got %b expected 0", ol); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rstemit_no_done: got %0d pulses expected 0", done_cnt - d0); end
    exp_idx = (exp_idx + 1) % NEURONS;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [8];
    logic [7:0] expq [8];
    logic [7:0] got [$];
    int acc_cyc [8];
    int n_acc, cyc, d0;
    load_random();
    for (int i = 0; i < 8; i++) begin vals[i] = 8'($urandom); expq[i] = ref_act(vals[i]); end
    d0 = done_cnt; n_acc = 0; cyc = 0;
    out_ready = 1'b1;
    while ((n_acc < 8 || got.size() < 8) && cyc < 300) begin
      @(negedge clk); cyc++;
      if (out_valid) got.push_back(out_data);
      if (n_acc < 8) begin
        in_valid = 1'b1;
        if (in_ready) begin in_data = vals[n_acc]; acc_cyc[n_acc] = cyc; n_acc++; end
        else in_data = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 4) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 4", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== expq[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, $signed(got[i]), $signed(expq[i])); end
    end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
  endtask

  task automatic test_random();
    logic [7:0] od, oi, d, e; logic ol, os, odn; logic [3:0] oa; int lat;
    load_random();
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      e = ref_act(d);
      run_item(d, $urandom_range(0, 3), od, ol, oi, oa, lat, os, odn);
      checks++; if (od !== e) begin errors++; $display("FAIL rand_data[%0d] in=%h: got %0d expected %0d", i, d, $signed(od), $signed(e)); end
      checks++; if (oi !== 8'(exp_idx)) begin errors++; $display("FAIL rand_idx[%0d]: got %0d expected %0d", i, oi, exp_idx); end
      checks++; if (ol !== (exp_idx == NEURONS - 1)) begin errors++; $display("FAIL rand_last[%0d]: got %b expected %b", i, ol, (exp_idx == NEURONS - 1)); end
      checks++; if (os !== 1'b1 || lat !== 2) begin errors++; $display("FAIL rand_timing[%0d]: latency %0d stable %b expected 2 and 1", i, lat, os); end
      exp_idx = (exp_idx + 1) % NEURONS;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    load_ramp();
    test_reset();
    test_ramp();
    test_downward();
    test_frame();
    test_reset_emit();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
